// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-request controller.
// Drives the external adder and issues valid/ready fetch requests.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter logic [31:0] PC_STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] add_a_o,
  output logic [31:0] add_b_o,
  input  logic [31:0] add_result_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        halt_i,
  output logic [31:0] pc_o,
  output logic        exc_valid_o,
  output logic [31:0] exc_addr_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {
    BOOT, FETCH, HALT, TRAP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] exc_addr_q, exc_addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        redir;
  logic        misal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      exc_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      exc_addr_q <= exc_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign redir = redirect_valid_i && (state_q != TRAP);
  assign misal = |redirect_target_i[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    exc_addr_d = exc_addr_q;
    cnt_d      = cnt_q;
    if (redir) begin
      // A redirect flushes any outstanding request
      if (misal) begin
        pc_d       = TRAP_VECTOR;
        exc_addr_d = redirect_target_i;
        state_d    = TRAP;
      end else begin
        pc_d = redirect_target_i;
        if (state_q == BOOT) state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        BOOT: state_d = halt_i ? HALT : FETCH;
        FETCH: begin
          if (req_ready_i) begin
            pc_d    = add_result_i;
            cnt_d   = cnt_q + 32'd1;
            state_d = halt_i ? HALT : FETCH;
          end
        end
        HALT: begin
          if (!halt_i) state_d = FETCH;
        end
        TRAP: state_d = halt_i ? HALT : FETCH;
      endcase
    end
  end

  always_comb begin
    req_valid_o = 1'b0;
    exc_valid_o = 1'b0;
    unique case (state_q)
      FETCH:   req_valid_o = 1'b1;
      TRAP:    exc_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign add_a_o       = pc_q;
  assign add_b_o       = PC_STEP;
  assign req_addr_o    = pc_q;
  assign pc_o          = pc_q;
  assign exc_addr_o    = exc_addr_q;
  assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl.
// Expected fetch addresses are queued and popped on each handshake.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] add_a, add_b, add_res;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        redir_v;
  logic [31:0] redir_t;
  logic        halt;
  logic [31:0] pc;
  logic        exc_v;
  logic [31:0] exc_a;
  logic [31:0] cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  assign add_res = add_a + add_b;

  pc_fetch_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .add_a_o           (add_a),
    .add_b_o           (add_b),
    .add_result_i      (add_res),
    .req_valid_o       (req_valid),
    .req_addr_o        (req_addr),
    .req_ready_i       (req_ready),
    .redirect_valid_i  (redir_v),
    .redirect_target_i (redir_t),
    .halt_i            (halt),
    .pc_o              (pc),
    .exc_valid_o       (exc_v),
    .exc_addr_o        (exc_a),
    .fetch_count_o     (cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor: inputs settle at posedge+1, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready && !redir_v) begin
      if (sb.size() == 0) begin
        chk("sb_empty", req_addr, 32'hDEAD_BEEF);
      end else begin
        chk("xfer_addr", req_addr, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_ready = 1'b0; redir_v = 1'b0;
    redir_t = '0; halt = 1'b0;
    cyc(); cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_exc", {31'b0, exc_v}, 32'd0);
    chk("rst_exca", exc_a, 32'h0);
    chk("rst_cnt", cnt, 32'd0);
    chk("add_b", add_b, 32'd4);

    // sequential fetch with a 3-cycle stall at 0x8
    sb.push_back(32'h0); sb.push_back(32'h4);
    sb.push_back(32'h8); sb.push_back(32'hC);
    rst = 1'b0; req_ready = 1'b1;
    chk("boot_valid", {31'b0, req_valid}, 32'd0);
    cyc();
    chk("first_valid", {31'b0, req_valid}, 32'd1);
    chk("first_addr", req_addr, 32'h0);
    cyc();
    chk("addr4", req_addr, 32'h4);
    chk("add_a", add_a, 32'h4);
    cyc();
    chk("addr8", req_addr, 32'h8);
    chk("cnt2", cnt, 32'd2);
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_addr", req_addr, 32'h8);
      chk("stall_valid", {31'b0, req_valid}, 32'd1);
      chk("stall_cnt", cnt, 32'd2);
    end
    req_ready = 1'b1;
    cyc();
    chk("addrC", req_addr, 32'hC);
    chk("cnt3", cnt, 32'd3);
    cyc();
    chk("addr10", req_addr, 32'h10);
    chk("cnt4", cnt, 32'd4);

    // redirect flushes a ready request
    redir_v = 1'b1; redir_t = 32'h200;
    cyc();
    redir_v = 1'b0; req_ready = 1'b0;
    chk("redir_pc", req_addr, 32'h200);
    chk("redir_cnt", cnt, 32'd4);
    chk("redir_valid", {31'b0, req_valid}, 32'd1);

    // misaligned redirect traps
    redir_v = 1'b1; redir_t = 32'h203;
    cyc();
    redir_v = 1'b0;
    chk("trap_exc", {31'b0, exc_v}, 32'd1);
    chk("trap_exca", exc_a, 32'h203);
    chk("trap_pc", pc, 32'h100);
    chk("trap_valid", {31'b0, req_valid}, 32'd0);
    cyc();
    chk("post_exc", {31'b0, exc_v}, 32'd0);
    chk("post_exca", exc_a, 32'h203);
    chk("resume_addr", req_addr, 32'h100);
    chk("resume_valid", {31'b0, req_valid}, 32'd1);
    sb.push_back(32'h100);
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    chk("cnt5", cnt, 32'd5);
    chk("pc104", pc, 32'h104);

    // halt waits for the handshake, then resumes
    redir_v = 1'b1; redir_t = 32'h20;
    cyc();
    redir_v = 1'b0;
    halt = 1'b1;
    cyc(); cyc();
    chk("halt_wait_v", {31'b0, req_valid}, 32'd1);
    chk("halt_wait_a", req_addr, 32'h20);
    sb.push_back(32'h20);
    req_ready = 1'b1;
    cyc();
    chk("halt_pc", pc, 32'h24);
    chk("halt_valid", {31'b0, req_valid}, 32'd0);
    chk("cnt6", cnt, 32'd6);
    cyc();
    chk("halt_hold_pc", pc, 32'h24);
    chk("halt_hold_cnt", cnt, 32'd6);
    halt = 1'b0; req_ready = 1'b0;
    cyc();
    chk("unhalt_valid", {31'b0, req_valid}, 32'd1);
    chk("unhalt_addr", req_addr, 32'h24);

    // 32-bit PC wrap
    redir_v = 1'b1; redir_t = 32'hFFFF_FFFC;
    cyc();
    redir_v = 1'b0;
    chk("pre_wrap", pc, 32'hFFFF_FFFC);
    sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0);
    req_ready = 1'b1;
    cyc();
    chk("wrap_pc", pc, 32'h0);
    chk("cnt7", cnt, 32'd7);
    cyc();
    chk("pc4", pc, 32'h4);
    chk("cnt8", cnt, 32'd8);

    // async reset mid-request
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'b0, req_valid}, 32'd0);
    chk("arst_cnt", cnt, 32'd0);
    chk("arst_exca", exc_a, 32'h0);
    cyc();
    chk("sb_left", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
